// File: rtl/reset_seq_pkg.sv
// Shared types and width helpers for the multi-domain reset sequencer.
package reset_seq_pkg;

  typedef enum logic [1:0] {
    ST_ASSERT  = 2'd0,
    ST_RELEASE = 2'd1,
    ST_RUN     = 2'd2
  } seq_state_e;

  function automatic int ctr_width(input int stretch, input int gap);
    return $clog2(((stretch > gap) ? stretch : gap) + 1);
  endfunction

  function automatic int idx_width(input int num_domains);
    return $clog2(num_domains + 1);
  endfunction

endpackage

// File: rtl/reset_sequencer.sv
// Multi-domain reset sequencer: stretches power-on/soft resets, then releases
// domains in order with a programmable gap; records sticky reset causes.
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int NUM_DOMAINS    = 2,
  parameter int NUM_REQ        = 2,
  parameter int STRETCH_CYCLES = 16,
  parameter int GAP_CYCLES     = 4
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic [NUM_REQ-1:0]     REQ,
  input  logic [NUM_DOMAINS-1:0] HOLD,
  input  logic                   CAUSE_CLR,
  output logic [NUM_DOMAINS-1:0] RST_N,
  output logic                   BUSY,
  output logic                   DONE,
  output logic [NUM_REQ-1:0]     CAUSE,
  output logic                   CAUSE_POR
);

  localparam int CTR_W = ctr_width(STRETCH_CYCLES, GAP_CYCLES);
  localparam int IDX_W = idx_width(NUM_DOMAINS);

  localparam logic [CTR_W-1:0] STRETCH_LD = CTR_W'(STRETCH_CYCLES - 1);
  localparam logic [CTR_W-1:0] GAP_LD     = CTR_W'(GAP_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_DOMAINS - 1);

  seq_state_e             state_q, state_d;
  logic [CTR_W-1:0]       ctr_q, ctr_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [NUM_DOMAINS-1:0] rst_n_q, rst_n_d;
  logic                   done_q, done_d;
  logic [NUM_REQ-1:0]     cause_q, cause_d;
  logic                   cause_por_q, cause_por_d;

  logic any_req;
  logic hold_idx;
  logic rel_fire;

  assign any_req = |REQ;

  always_comb begin
    hold_idx = 1'b0;
    for (int k = 0; k < NUM_DOMAINS; k++) begin
      if (IDX_W'(k) == idx_q) hold_idx = HOLD[k];
    end
  end

  // Gap has expired and the domain being released is not held back.
  assign rel_fire = (state_q == ST_RELEASE) && (ctr_q == '0) && !hold_idx;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= ST_ASSERT;
      ctr_q   <= STRETCH_LD;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      ctr_q   <= ctr_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ctr_d   = ctr_q;
    idx_d   = idx_q;
    if (any_req) begin
      state_d = ST_ASSERT;
      ctr_d   = STRETCH_LD;
      idx_d   = '0;
    end else begin
      case (state_q)
        ST_ASSERT: begin
          if (ctr_q == '0) begin
            idx_d   = IDX_W'(1);
            ctr_d   = GAP_LD;
            state_d = (NUM_DOMAINS == 1) ? ST_RUN : ST_RELEASE;
          end else begin
            ctr_d = ctr_q - CTR_W'(1);
          end
        end
        ST_RELEASE: begin
          if (ctr_q != '0) begin
            ctr_d = ctr_q - CTR_W'(1);
          end else if (rel_fire) begin
            idx_d = idx_q + IDX_W'(1);
            ctr_d = GAP_LD;
            if (idx_q == LAST_IDX) state_d = ST_RUN;
          end
        end
        default: ;
      endcase
    end
  end

  // Next values of the registered outputs; REQ overrides hold and release.
  always_comb begin
    rst_n_d     = rst_n_q;
    done_d      = 1'b0;
    cause_d     = (cause_q & ~{NUM_REQ{CAUSE_CLR}}) | REQ;
    cause_por_d = cause_por_q & ~CAUSE_CLR;
    if (any_req) begin
      rst_n_d = '0;
    end else begin
      case (state_q)
        ST_ASSERT: begin
          if (ctr_q == '0) begin
            rst_n_d[0] = 1'b1;
            done_d     = (NUM_DOMAINS == 1);
          end
        end
        ST_RELEASE: begin
          for (int k = 0; k < NUM_DOMAINS; k++) begin
            if (IDX_W'(k) < idx_q) rst_n_d[k] = ~HOLD[k];
            else if ((IDX_W'(k) == idx_q) && rel_fire) rst_n_d[k] = 1'b1;
          end
          done_d = rel_fire && (idx_q == LAST_IDX);
        end
        ST_RUN: rst_n_d = ~HOLD;
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      rst_n_q     <= '0;
      done_q      <= 1'b0;
      cause_q     <= '0;
      cause_por_q <= 1'b1;
    end else begin
      rst_n_q     <= rst_n_d;
      done_q      <= done_d;
      cause_q     <= cause_d;
      cause_por_q <= cause_por_d;
    end
  end

  assign RST_N     = rst_n_q;
  assign BUSY      = (state_q != ST_RUN);
  assign DONE      = done_q;
  assign CAUSE     = cause_q;
  assign CAUSE_POR = cause_por_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Self-checking bench for reset_sequencer: directed table, corner sequences,
// and randomized traffic against a release-time reference model.
module tb_reset_sequencer;

  localparam int ND = 3;
  localparam int NR = 2;
  localparam int SC = 16;
  localparam int GC = 4;

  logic          CLK;
  logic          RESET;
  logic [NR-1:0] REQ;
  logic [ND-1:0] HOLD;
  logic          CAUSE_CLR;
  logic [ND-1:0] RST_N;
  logic          BUSY;
  logic          DONE;
  logic [NR-1:0] CAUSE;
  logic          CAUSE_POR;

  int checks   = 0;
  int failures = 0;

  // Reference model: edge count, last edge REQ was sampled, per-domain release edge.
  int            m_n;
  int            m_last;
  int            m_rel [ND];
  logic [ND-1:0] m_rst;
  logic          m_done;
  logic [NR-1:0] m_cause;
  logic          m_por;

  typedef struct {
    int            edge_n;
    logic [NR-1:0] req;
    logic [ND-1:0] hold;
    logic          clr;
    logic [ND-1:0] rst_n;
    logic          done;
    logic          busy;
    logic [NR-1:0] cause;
    logic          por;
  } vec_t;

  vec_t vec [20];

  reset_sequencer #(
    .NUM_DOMAINS   (ND),
    .NUM_REQ       (NR),
    .STRETCH_CYCLES(SC),
    .GAP_CYCLES    (GC)
  ) dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .REQ      (REQ),
    .HOLD     (HOLD),
    .CAUSE_CLR(CAUSE_CLR),
    .RST_N    (RST_N),
    .BUSY     (BUSY),
    .DONE     (DONE),
    .CAUSE    (CAUSE),
    .CAUSE_POR(CAUSE_POR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (edge %0d)", name, act, exp, m_n);
    end
  endtask

  function automatic void model_reset();
    m_n     = 0;
    m_last  = 0;
    for (int k = 0; k < ND; k++) m_rel[k] = -1;
    m_rst   = '0;
    m_done  = 1'b0;
    m_cause = '0;
    m_por   = 1'b1;
  endfunction

  function automatic void model_edge(input logic [NR-1:0] r, input logic [ND-1:0] h, input logic c);
    m_n++;
    m_done  = 1'b0;
    m_cause = (m_cause & ~{NR{c}}) | r;
    if (c) m_por = 1'b0;
    if (|r) begin
      m_last = m_n;
      m_rst  = '0;
      for (int k = 0; k < ND; k++) m_rel[k] = -1;
    end else begin
      for (int k = 0; k < ND; k++) begin
        if (m_rel[k] >= 0) begin
          m_rst[k] = ~h[k];
        end else begin
          logic ok;
          if (k == 0) ok = (m_n >= m_last + SC);
          else        ok = (m_rel[k-1] >= 0) && (m_n >= m_rel[k-1] + GC) && !h[k];
          if (ok) begin
            m_rel[k] = m_n;
            m_rst[k] = 1'b1;
            if (k == ND - 1) m_done = 1'b1;
          end
        end
      end
    end
  endfunction

  task automatic compare_model();
    chk("model_rst_n", 32'(RST_N), 32'(m_rst));
    chk("model_done", 32'(DONE), 32'(m_done));
    chk("model_busy", 32'(BUSY), 32'(m_rel[ND-1] < 0));
    chk("model_cause", 32'(CAUSE), 32'(m_cause));
    chk("model_por", 32'(CAUSE_POR), 32'(m_por));
  endtask

  // Entered between edges; drives inputs, clocks one edge, checks, returns at negedge.
  task automatic step(input logic [NR-1:0] r, input logic [ND-1:0] h, input logic c);
    REQ = r;
    HOLD = h;
    CAUSE_CLR = c;
    @(posedge CLK);
    model_edge(r, h, c);
    #1;
    compare_model();
    @(negedge CLK);
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    REQ = '0;
    HOLD = '0;
    CAUSE_CLR = 1'b0;
    model_reset();
    @(negedge CLK);
    @(negedge CLK);
    RESET = 1'b0;
  endtask

  initial begin
    logic [ND-1:0] h;
    logic [NR-1:0] r;
    logic          c;

    vec[0]  = '{15, 2'b00, 3'b000, 1'b0, 3'b000, 1'b0, 1'b1, 2'b00, 1'b1};
    vec[1]  = '{16, 2'b00, 3'b000, 1'b0, 3'b001, 1'b0, 1'b1, 2'b00, 1'b1};
    vec[2]  = '{19, 2'b00, 3'b000, 1'b0, 3'b001, 1'b0, 1'b1, 2'b00, 1'b1};
    vec[3]  = '{20, 2'b00, 3'b000, 1'b0, 3'b011, 1'b0, 1'b1, 2'b00, 1'b1};
    vec[4]  = '{23, 2'b00, 3'b000, 1'b0, 3'b011, 1'b0, 1'b1, 2'b00, 1'b1};
    vec[5]  = '{24, 2'b00, 3'b000, 1'b0, 3'b111, 1'b1, 1'b0, 2'b00, 1'b1};
    vec[6]  = '{25, 2'b00, 3'b000, 1'b0, 3'b111, 1'b0, 1'b0, 2'b00, 1'b1};
    vec[7]  = '{26, 2'b00, 3'b010, 1'b0, 3'b101, 1'b0, 1'b0, 2'b00, 1'b1};
    vec[8]  = '{28, 2'b00, 3'b010, 1'b0, 3'b101, 1'b0, 1'b0, 2'b00, 1'b1};
    vec[9]  = '{29, 2'b00, 3'b000, 1'b0, 3'b111, 1'b0, 1'b0, 2'b00, 1'b1};
    vec[10] = '{30, 2'b10, 3'b000, 1'b0, 3'b000, 1'b0, 1'b1, 2'b10, 1'b1};
    vec[11] = '{45, 2'b00, 3'b000, 1'b0, 3'b000, 1'b0, 1'b1, 2'b10, 1'b1};
    vec[12] = '{46, 2'b00, 3'b000, 1'b0, 3'b001, 1'b0, 1'b1, 2'b10, 1'b1};
    vec[13] = '{50, 2'b00, 3'b000, 1'b0, 3'b011, 1'b0, 1'b1, 2'b10, 1'b1};
    vec[14] = '{54, 2'b00, 3'b000, 1'b0, 3'b111, 1'b1, 1'b0, 2'b10, 1'b1};
    vec[15] = '{55, 2'b00, 3'b000, 1'b1, 3'b111, 1'b0, 1'b0, 2'b00, 1'b0};
    vec[16] = '{65, 2'b01, 3'b000, 1'b0, 3'b000, 1'b0, 1'b1, 2'b01, 1'b0};
    vec[17] = '{80, 2'b00, 3'b000, 1'b0, 3'b000, 1'b0, 1'b1, 2'b01, 1'b0};
    vec[18] = '{81, 2'b00, 3'b000, 1'b0, 3'b001, 1'b0, 1'b1, 2'b01, 1'b0};
    vec[19] = '{89, 2'b00, 3'b000, 1'b0, 3'b111, 1'b1, 1'b0, 2'b01, 1'b0};

    // Power-on reset values.
    RESET = 1'b1;
    REQ = '0;
    HOLD = '0;
    CAUSE_CLR = 1'b0;
    model_reset();
    @(negedge CLK);
    chk("por_rst_n", 32'(RST_N), 32'h0);
    chk("por_busy", 32'(BUSY), 32'h1);
    chk("por_done", 32'(DONE), 32'h0);
    chk("por_cause", 32'(CAUSE), 32'h0);
    chk("por_cause_por", 32'(CAUSE_POR), 32'h1);
    @(negedge CLK);
    RESET = 1'b0;

    for (int i = 0; i < 20; i++) begin
      while (m_n < vec[i].edge_n) step(vec[i].req, vec[i].hold, vec[i].clr);
      chk($sformatf("tbl%0d_rst_n", i), 32'(RST_N), 32'(vec[i].rst_n));
      chk($sformatf("tbl%0d_done", i), 32'(DONE), 32'(vec[i].done));
      chk($sformatf("tbl%0d_busy", i), 32'(BUSY), 32'(vec[i].busy));
      chk($sformatf("tbl%0d_cause", i), 32'(CAUSE), 32'(vec[i].cause));
      chk($sformatf("tbl%0d_por", i), 32'(CAUSE_POR), 32'(vec[i].por));
    end

    // HOLD[2] high from edge 18 through 30 stalls the last release to edge 31.
    do_reset();
    while (m_n < 17) step(2'b00, 3'b000, 1'b0);
    while (m_n < 30) begin
      step(2'b00, 3'b100, 1'b0);
      if (m_n == 24) chk("hold2_e24_rst_n", 32'(RST_N), 32'h3);
    end
    chk("hold2_e30_rst_n", 32'(RST_N), 32'h3);
    chk("hold2_e30_busy", 32'(BUSY), 32'h1);
    step(2'b00, 3'b000, 1'b0);
    chk("hold2_e31_rst_n", 32'(RST_N), 32'h7);
    chk("hold2_e31_done", 32'(DONE), 32'h1);
    chk("hold2_e31_busy", 32'(BUSY), 32'h0);

    // Asynchronous reset mid-sequence, then CAUSE_CLR together with REQ[0].
    do_reset();
    while (m_n < 21) step(2'b00, 3'b000, 1'b0);
    chk("mid_e21_rst_n", 32'(RST_N), 32'h3);
    RESET = 1'b1;
    model_reset();
    #1;
    chk("async_rst_n", 32'(RST_N), 32'h0);
    chk("async_busy", 32'(BUSY), 32'h1);
    chk("async_por", 32'(CAUSE_POR), 32'h1);
    @(negedge CLK);
    RESET = 1'b0;
    step(2'b01, 3'b000, 1'b1);
    chk("clr_req_cause", 32'(CAUSE), 32'h1);
    chk("clr_req_por", 32'(CAUSE_POR), 32'h0);
    while (m_n < 16) step(2'b00, 3'b000, 1'b0);
    chk("clr_req_e16_rst_n", 32'(RST_N), 32'h0);
    step(2'b00, 3'b000, 1'b0);
    chk("clr_req_e17_rst_n", 32'(RST_N), 32'h1);

    // Randomized traffic against the model.
    do_reset();
    h = '0;
    for (int i = 0; i < 2000; i++) begin
      r = ($urandom_range(0, 39) == 0) ? NR'($urandom_range(1, 3)) : '0;
      if ($urandom_range(0, 5) == 0) h[$urandom_range(0, ND - 1)] ^= 1'b1;
      c = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 399) == 0) begin
        RESET = 1'b1;
        model_reset();
        #1;
        compare_model();
        @(negedge CLK);
        RESET = 1'b0;
      end
      step(r, h, c);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
